// File: rtl/frogger_hazard_engine_pkg.sv
// frogger_hazard_engine_pkg: shared playfield constants, FSM states and sizing helper
package frogger_hazard_engine_pkg;
  localparam int GAME_WIDTH  = 14;
  localparam int COORD_W     = 6;
  localparam int NUM_CARS    = 5;
  localparam int NUM_LOGS    = 3;
  localparam int CAR_LEN     = 2;
  localparam int LOG_LEN     = 3;
  localparam int WATER_Y_MIN = 1;
  localparam int WATER_Y_MAX = 5;
  localparam int COOLDOWN    = 60;
  typedef enum logic [1:0] {IDLE, SCAN_CARS, SCAN_LOGS, RESOLVE} state_t;
  function automatic int clog2_min1(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/frogger_hazard_engine_wrap_overlap.sv
// frogger_wrap_overlap: combinational test of frog (i_xf,i_yf) against an obstacle at (i_xo,i_yo) of length i_len with horizontal wrap; o_hit=1 on overlap
module frogger_wrap_overlap
  import frogger_hazard_engine_pkg::*;
#(
  parameter int c_GAME_WIDTH = GAME_WIDTH,
  parameter int c_COORD_W    = COORD_W
) (
  input  logic [c_COORD_W-1:0] i_xf,
  input  logic [c_COORD_W-1:0] i_yf,
  input  logic [c_COORD_W-1:0] i_xo,
  input  logic [c_COORD_W-1:0] i_yo,
  input  logic [c_COORD_W:0]   i_len,
  output logic                 o_hit
);
  localparam logic [c_COORD_W:0] W = (c_COORD_W+1)'(c_GAME_WIDTH);
  logic [c_COORD_W:0] xf, xo, yf, yo, d;
  logic on_screen;
  always_comb begin
    xf = {1'b0, i_xf};
    xo = {1'b0, i_xo};
    yf = {1'b0, i_yf};
    yo = {1'b0, i_yo};
    d = xf >= xo ? xf - xo : W - (xo - xf);
    on_screen = xf < W && xo < W && yf < W && yo < W;
    o_hit = on_screen && yf == yo && d < i_len;
  end
endmodule

// File: rtl/frogger_hazard_engine.sv
// frogger_hazard_engine: per-frame sequential scan of cars/logs against the frog; reports collision, drowning, log ride, respawn pulse, cooldown and dropped ticks
module frogger_hazard_engine
  import frogger_hazard_engine_pkg::*;
#(
  parameter int c_GAME_WIDTH  = GAME_WIDTH,
  parameter int c_COORD_W     = COORD_W,
  parameter int c_NUM_CARS    = NUM_CARS,
  parameter int c_NUM_LOGS    = NUM_LOGS,
  parameter int c_CAR_LEN     = CAR_LEN,
  parameter int c_LOG_LEN     = LOG_LEN,
  parameter int c_WATER_Y_MIN = WATER_Y_MIN,
  parameter int c_WATER_Y_MAX = WATER_Y_MAX,
  parameter int c_COOLDOWN    = COOLDOWN,
  localparam int LIW = clog2_min1(c_NUM_LOGS)
) (
  input  logic                             i_Clk,
  input  logic                             i_Reset,
  input  logic                             i_Frame_Tick,
  input  logic [c_COORD_W-1:0]             i_Frogger_X,
  input  logic [c_COORD_W-1:0]             i_Frogger_Y,
  input  logic [c_NUM_CARS*c_COORD_W-1:0]  i_Car_X,
  input  logic [c_NUM_CARS*c_COORD_W-1:0]  i_Car_Y,
  input  logic [c_NUM_LOGS*c_COORD_W-1:0]  i_Log_X,
  input  logic [c_NUM_LOGS*c_COORD_W-1:0]  i_Log_Y,
  output logic                             o_Busy,
  output logic                             o_Done,
  output logic                             o_Collided,
  output logic                             o_Drowned,
  output logic                             o_On_Log,
  output logic [LIW-1:0]                   o_Log_Idx,
  output logic                             o_Respawn,
  output logic                             o_Invulnerable,
  output logic                             o_Tick_Dropped
);
  localparam int IW  = clog2_min1(c_NUM_CARS > c_NUM_LOGS ? c_NUM_CARS : c_NUM_LOGS);
  localparam int CDW = clog2_min1(c_COOLDOWN + 1);
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [c_COORD_W-1:0] fx_q, fx_d, fy_q, fy_d;
  logic [c_NUM_CARS*c_COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [c_NUM_LOGS*c_COORD_W-1:0] lx_q, lx_d, ly_q, ly_d;
  logic inv_q, inv_d, car_hit_q, car_hit_d, log_hit_q, log_hit_d;
  logic [LIW-1:0] log_idx_q, log_idx_d, out_idx_q, out_idx_d;
  logic [CDW-1:0] cd_q, cd_d;
  logic done_q, done_d, col_q, col_d, drn_q, drn_d, on_q, on_d, resp_q, resp_d;
  logic [c_COORD_W-1:0] ob_x, ob_y;
  logic [c_COORD_W:0] ob_len;
  logic hit, car_last, log_last, water, drown, death;
  // one overlap unit shared by both phases; the obstacle and its length follow the scan phase
  always_comb begin
    ob_x = state_q == SCAN_CARS ? cx_q[int'(idx_q)*c_COORD_W +: c_COORD_W] : lx_q[int'(idx_q)*c_COORD_W +: c_COORD_W];
    ob_y = state_q == SCAN_CARS ? cy_q[int'(idx_q)*c_COORD_W +: c_COORD_W] : ly_q[int'(idx_q)*c_COORD_W +: c_COORD_W];
    ob_len = state_q == SCAN_CARS ? (c_COORD_W+1)'(c_CAR_LEN) : (c_COORD_W+1)'(c_LOG_LEN);
  end
  frogger_wrap_overlap #(.c_GAME_WIDTH(c_GAME_WIDTH), .c_COORD_W(c_COORD_W)) u_overlap (
    .i_xf(fx_q), .i_yf(fy_q), .i_xo(ob_x), .i_yo(ob_y), .i_len(ob_len), .o_hit(hit)
  );
  assign o_Busy         = state_q != IDLE;
  assign o_Tick_Dropped = i_Frame_Tick && o_Busy;
  assign o_Done         = done_q;
  assign o_Collided     = col_q;
  assign o_Drowned      = drn_q;
  assign o_On_Log       = on_q;
  assign o_Log_Idx      = out_idx_q;
  assign o_Respawn      = resp_q;
  assign o_Invulnerable = cd_q != '0;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    fx_d = fx_q;
    fy_d = fy_q;
    cx_d = cx_q;
    cy_d = cy_q;
    lx_d = lx_q;
    ly_d = ly_q;
    inv_d = inv_q;
    car_hit_d = car_hit_q;
    log_hit_d = log_hit_q;
    log_idx_d = log_idx_q;
    out_idx_d = out_idx_q;
    col_d = col_q;
    drn_d = drn_q;
    on_d = on_q;
    done_d = 1'b0;
    resp_d = 1'b0;
    car_last = idx_q == IW'(c_NUM_CARS - 1);
    log_last = idx_q == IW'(c_NUM_LOGS - 1);
    water = fy_q >= c_COORD_W'(c_WATER_Y_MIN) && fy_q <= c_COORD_W'(c_WATER_Y_MAX);
    drown = water && !log_hit_q && !car_hit_q;
    death = !inv_q && (car_hit_q || drown);
    // every tick ages the cooldown, whether or not it starts a scan
    cd_d = i_Frame_Tick && cd_q != '0 ? cd_q - 1'b1 : cd_q;
    case (state_q)
      IDLE: if (i_Frame_Tick) begin
        state_d = SCAN_CARS;
        idx_d = '0;
        fx_d = i_Frogger_X;
        fy_d = i_Frogger_Y;
        cx_d = i_Car_X;
        cy_d = i_Car_Y;
        lx_d = i_Log_X;
        ly_d = i_Log_Y;
        inv_d = cd_q != '0;
        car_hit_d = 1'b0;
        log_hit_d = 1'b0;
        log_idx_d = '0;
      end
      SCAN_CARS: begin
        car_hit_d = car_hit_q || hit;
        idx_d = car_last ? '0 : idx_q + 1'b1;
        state_d = car_last ? SCAN_LOGS : SCAN_CARS;
      end
      SCAN_LOGS: begin
        log_hit_d = log_hit_q || hit;
        log_idx_d = hit && !log_hit_q ? LIW'(idx_q) : log_idx_q;
        idx_d = log_last ? '0 : idx_q + 1'b1;
        state_d = log_last ? RESOLVE : SCAN_LOGS;
      end
      default: begin
        state_d = IDLE;
        done_d = 1'b1;
        col_d = !inv_q && car_hit_q;
        drn_d = !inv_q && drown;
        on_d = log_hit_q;
        out_idx_d = log_idx_q;
        resp_d = death;
        cd_d = death ? CDW'(c_COOLDOWN) : cd_d;
      end
    endcase
  end
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      fx_q <= '0;
      fy_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
      lx_q <= '0;
      ly_q <= '0;
      inv_q <= 1'b0;
      car_hit_q <= 1'b0;
      log_hit_q <= 1'b0;
      log_idx_q <= '0;
      out_idx_q <= '0;
      cd_q <= '0;
      done_q <= 1'b0;
      col_q <= 1'b0;
      drn_q <= 1'b0;
      on_q <= 1'b0;
      resp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      fx_q <= fx_d;
      fy_q <= fy_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
      lx_q <= lx_d;
      ly_q <= ly_d;
      inv_q <= inv_d;
      car_hit_q <= car_hit_d;
      log_hit_q <= log_hit_d;
      log_idx_q <= log_idx_d;
      out_idx_q <= out_idx_d;
      cd_q <= cd_d;
      done_q <= done_d;
      col_q <= col_d;
      drn_q <= drn_d;
      on_q <= on_d;
      resp_q <= resp_d;
    end
  end
endmodule

// File: tb/tb_frogger_hazard_engine.sv
// tb_frogger_hazard_engine: directed and randomized self-checking bench for frogger_hazard_engine
module tb_frogger_hazard_engine;
  localparam int W = 14, CW = 6, N = 5, M = 3;
  logic clk = 0, rst = 1, tick = 0;
  logic [CW-1:0] fxs, fys;
  logic [N*CW-1:0] cxb, cyb;
  logic [M*CW-1:0] lxb, lyb;
  logic busy, done, col, drn, on_log, resp, inv, dropped;
  logic [1:0] lidx;
  int car_x[N], car_y[N], log_x[M], log_y[M];
  int frog_x, frog_y, cd;
  int errors = 0, checks = 0;
  frogger_hazard_engine dut (
    .i_Clk(clk), .i_Reset(rst), .i_Frame_Tick(tick),
    .i_Frogger_X(fxs), .i_Frogger_Y(fys),
    .i_Car_X(cxb), .i_Car_Y(cyb), .i_Log_X(lxb), .i_Log_Y(lyb),
    .o_Busy(busy), .o_Done(done), .o_Collided(col), .o_Drowned(drn),
    .o_On_Log(on_log), .o_Log_Idx(lidx), .o_Respawn(resp),
    .o_Invulnerable(inv), .o_Tick_Dropped(dropped)
  );
  always #5 clk = ~clk;
  task automatic park();
    for (int k = 0; k < N; k++) begin car_x[k] = 15; car_y[k] = 63; end
    for (int k = 0; k < M; k++) begin log_x[k] = 15; log_y[k] = 63; end
  endtask
  task automatic apply();
    fxs = CW'(frog_x);
    fys = CW'(frog_y);
    for (int k = 0; k < N; k++) begin cxb[k*CW +: CW] = CW'(car_x[k]); cyb[k*CW +: CW] = CW'(car_y[k]); end
    for (int k = 0; k < M; k++) begin lxb[k*CW +: CW] = CW'(log_x[k]); lyb[k*CW +: CW] = CW'(log_y[k]); end
  endtask
  function automatic bit ovl(int xf, int yf, int xo, int yo, int len);
    if (xf >= W || yf >= W || xo >= W || yo >= W) return 0;
    return yf == yo && ((((xf - xo) % W) + W) % W) < len;
  endfunction
  task automatic model(input bit inv_pre, output logic [6:0] exp);
    bit car_hit = 0, on = 0, water, c, d;
    int idx = 0;
    for (int k = 0; k < N; k++) if (ovl(frog_x, frog_y, car_x[k], car_y[k], 2)) car_hit = 1;
    for (int k = M - 1; k >= 0; k--) if (ovl(frog_x, frog_y, log_x[k], log_y[k], 3)) begin on = 1; idx = k; end
    water = frog_y >= 1 && frog_y <= 5;
    c = !inv_pre && car_hit;
    d = !inv_pre && !car_hit && water && !on;
    if (c || d) cd = 60;
    exp = {c, d, on, 2'(idx), c || d, cd != 0};
  endtask
  task automatic do_reset();
    @(posedge clk); #1 rst = 1; tick = 0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 0;
    cd = 0;
  endtask
  // ticks, then counts cycles to o_Done; drop_at>0 scrambles live inputs and fires an extra tick at t+drop_at
  task automatic scan(input int drop_at, output int lat, output int busy_cnt, output bit dseen, output bit inv_pre);
    @(posedge clk); #1 tick = 1;
    inv_pre = cd != 0;
    if (cd > 0) cd--;
    lat = -1; busy_cnt = 0; dseen = 0;
    for (int k = 1; k < 40; k++) begin
      @(posedge clk); #1 tick = 0;
      if (drop_at > 0 && k == 1) begin fxs = 6'd40; cxb = '1; lxb = '1; end
      if (k == drop_at) begin tick = 1; if (cd > 0) cd--; end
      @(negedge clk);
      if (k == drop_at) dseen = dropped && busy;
      if (done) begin lat = k; break; end
      if (busy) busy_cnt++;
    end
    #1 tick = 0;
  endtask
  task automatic run(input int drop_at, output logic [6:0] exp, output int lat, output int bc, output bit ds);
    bit ip;
    apply();
    scan(drop_at, lat, bc, ds, ip);
    model(ip, exp);
  endtask
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if ({busy, done, col, drn, on_log, lidx, resp, inv, dropped} !== 10'b0) begin errors++; $display("FAIL reset_outputs got=%b exp=0", {busy, done, col, drn, on_log, lidx, resp, inv, dropped}); end
  endtask
  task automatic test_car_hit();
    logic [6:0] e; int lat, bc; bit ds;
    do_reset(); park();
    frog_x = 3; frog_y = 7; car_x[0] = 2; car_y[0] = 7;
    run(0, e, lat, bc, ds);
    checks++; if (lat !== 10) begin errors++; $display("FAIL car_latency got=%0d exp=10", lat); end
    checks++; if (bc !== 9) begin errors++; $display("FAIL car_busy_cycles got=%0d exp=9", bc); end
    checks++; if ({col, drn, resp, inv} !== 4'b1011) begin errors++; $display("FAIL car_hit got=%b exp=1011", {col, drn, resp, inv}); end
    @(negedge clk);
    checks++; if ({done, resp, col} !== 3'b001) begin errors++; $display("FAIL car_pulses got=%b exp=001", {done, resp, col}); end
  endtask
  task automatic test_wrap();
    logic [6:0] e; int lat, bc; bit ds;
    do_reset(); park();
    frog_x = 0; frog_y = 8; car_x[2] = 13; car_y[2] = 8;
    run(0, e, lat, bc, ds);
    checks++; if (col !== 1'b1) begin errors++; $display("FAIL wrap_hit got=%b exp=1", col); end
    do_reset();
    frog_x = 1;
    run(0, e, lat, bc, ds);
    checks++; if ({col, resp} !== 2'b00) begin errors++; $display("FAIL wrap_miss got=%b exp=00", {col, resp}); end
    frog_x = 0; car_x[2] = 14;
    run(0, e, lat, bc, ds);
    checks++; if ({col, resp} !== 2'b00) begin errors++; $display("FAIL offscreen got=%b exp=00", {col, resp}); end
  endtask
  task automatic test_water();
    logic [6:0] e; int lat, bc; bit ds;
    do_reset(); park();
    frog_x = 6; frog_y = 3; log_x[1] = 5; log_y[1] = 3; log_x[2] = 4; log_y[2] = 3;
    run(0, e, lat, bc, ds);
    checks++; if ({on_log, lidx, drn, col, resp} !== 6'b101000) begin errors++; $display("FAIL on_log got=%b exp=101000", {on_log, lidx, drn, col, resp}); end
    log_y[1] = 0; log_y[2] = 0;
    run(0, e, lat, bc, ds);
    checks++; if ({on_log, drn, col, resp, inv} !== 5'b01011) begin errors++; $display("FAIL drown got=%b exp=01011", {on_log, drn, col, resp, inv}); end
  endtask
  task automatic test_priority();
    logic [6:0] e; int lat, bc; bit ds;
    do_reset(); park();
    frog_x = 5; frog_y = 2; car_x[4] = 4; car_y[4] = 2;
    run(0, e, lat, bc, ds);
    checks++; if ({col, drn, resp} !== 3'b101) begin errors++; $display("FAIL priority got=%b exp=101", {col, drn, resp}); end
  endtask
  task automatic test_cooldown();
    logic [6:0] e; int lat, bc, bad; bit ds;
    do_reset(); park();
    frog_x = 7; frog_y = 9; car_x[1] = 6; car_y[1] = 9;
    run(0, e, lat, bc, ds);
    checks++; if ({col, resp, inv} !== 3'b111) begin errors++; $display("FAIL cd_first got=%b exp=111", {col, resp, inv}); end
    bad = 0;
    for (int i = 1; i <= 60; i++) begin
      run(0, e, lat, bc, ds);
      if ({col, resp} !== 2'b00 || inv !== (i < 60)) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL cd_window got=%0d bad_scans exp=0", bad); end
    run(0, e, lat, bc, ds);
    checks++; if ({col, resp, inv} !== 3'b111) begin errors++; $display("FAIL cd_expire got=%b exp=111", {col, resp, inv}); end
  endtask
  task automatic test_back_to_back();
    logic [6:0] e; int lat, bc; bit ds;
    do_reset(); park();
    frog_x = 3; frog_y = 7; car_x[0] = 2; car_y[0] = 7;
    run(3, e, lat, bc, ds);
    checks++; if (ds !== 1'b1) begin errors++; $display("FAIL drop_pulse got=%b exp=1", ds); end
    checks++; if ({lat, col, resp} !== {32'd10, 2'b11}) begin errors++; $display("FAIL drop_result lat=%0d col=%b resp=%b exp=10,1,1", lat, col, resp); end
    do_reset();
    frog_x = 5; frog_y = 4; car_y[0] = 63;
    run(9, e, lat, bc, ds);
    checks++; if (ds !== 1'b1) begin errors++; $display("FAIL drop_resolve got=%b exp=1", ds); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_no_start got=%b exp=0", busy); end
  endtask
  task automatic test_reset_mid();
    logic [6:0] e; int lat, bc, seen; bit ds;
    do_reset(); park();
    frog_x = 3; frog_y = 7; car_x[0] = 2; car_y[0] = 7;
    apply();
    @(posedge clk); #1 tick = 1;
    @(posedge clk); #1 tick = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    cd = 0; seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if ({busy, done, col, drn, on_log, lidx, resp, inv} !== 9'b0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL reset_abort got=%0d active_cycles exp=0", seen); end
    run(0, e, lat, bc, ds);
    checks++; if ({lat, col, resp} !== {32'd10, 2'b11}) begin errors++; $display("FAIL reset_rescan lat=%0d col=%b resp=%b exp=10,1,1", lat, col, resp); end
  endtask
  task automatic test_random();
    logic [6:0] e; int lat, bc; bit ds;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      if (i % 8 == 0) do_reset();
      frog_x = $urandom_range(0, 14); frog_y = $urandom_range(0, 4);
      for (int k = 0; k < N; k++) begin car_x[k] = $urandom_range(0, 15); car_y[k] = $urandom_range(0, 8); end
      for (int k = 0; k < M; k++) begin log_x[k] = $urandom_range(0, 15); log_y[k] = $urandom_range(0, 4); end
      run(0, e, lat, bc, ds);
      checks++; if ({col, drn, on_log, lidx, resp, inv} !== e || lat !== 10) begin
        errors++; $display("FAIL random_%0d got=%b lat=%0d exp=%b lat=10", i, {col, drn, on_log, lidx, resp, inv}, lat, e);
      end
    end
  endtask
  initial begin
    park(); frog_x = 0; frog_y = 0; cd = 0; apply();
    test_reset();
    test_car_hit();
    test_wrap();
    test_water();
    test_priority();
    test_cooldown();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
